// File: rtl/cnn_pkg.sv
// Shared pixel type, pooling FSM states and the 3-way signed max used by the
// layer-1 max-pool stage.
package cnn_pkg;

  localparam int PIX_W = 16;

  typedef logic signed [PIX_W-1:0] pix_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } pool_state_t;

  function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
    pix_t m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Two-row column store: lb1 holds the previous row, lb2 the row before it.
// A write pushes the current pixel into lb1 and the old lb1 entry into lb2.
module pool_line_buffer #(
  parameter int IN_DIM = 55,
  parameter int DATA_W = 16
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(IN_DIM)-1:0]  idx,
  input  logic signed [DATA_W-1:0]   wdata,
  output logic signed [DATA_W-1:0]   lb1_q,
  output logic signed [DATA_W-1:0]   lb2_q
);

  logic signed [DATA_W-1:0] lb1 [IN_DIM];
  logic signed [DATA_W-1:0] lb2 [IN_DIM];

  assign lb1_q = lb1[idx];
  assign lb2_q = lb2[idx];

  // Storage is deliberately unreset; rows 0 and 1 of every plane refill it
  // before any window that reads it can be emitted.
  always_ff @(posedge clk) begin
    if (we) begin
      lb2[idx] <= lb1[idx];
      lb1[idx] <= wdata;
    end
  end

endmodule

// File: rtl/maxpool1_3x3s2.sv
// Streaming 3x3 / stride-2 max-pool over raster-ordered planes, one pooled
// pixel per qualifying input, valid/ready on both sides, start/done framing.
module maxpool1_3x3s2
  import cnn_pkg::*;
#(
  parameter int DATA_W   = PIX_W,
  parameter int IN_DIM   = 55,
  parameter int K        = 3,
  parameter int STRIDE   = 2,
  parameter int CHANNELS = 96
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_last,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] out_chan,
  output logic                     busy,
  output logic                     done
);

  localparam int OUT_DIM = (IN_DIM - K) / STRIDE + 1;
  localparam int IDX_W   = $clog2(IN_DIM);
  localparam int CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(IN_DIM - 1);
  localparam logic [IDX_W-1:0]  WIN_FIRST = IDX_W'(K - 1);
  localparam logic [IDX_W-1:0]  STRIDE_W  = IDX_W'(STRIDE);
  localparam logic [IDX_W-1:0]  LAST_POS  = IDX_W'((OUT_DIM - 1) * STRIDE + K - 1);
  localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(CHANNELS - 1);

  pool_state_t       state;
  logic [IDX_W-1:0]  col;
  logic [IDX_W-1:0]  row;
  logic [CHAN_W-1:0] chan;
  logic              plane_overrun;

  pix_t lb1_q, lb2_q;
  pix_t v, h1, h2;

  logic accept;
  logic qualify;
  logic row_end;
  logic plane_end;
  logic frame_end;
  logic final_out;

  assign busy = (state == RUN);
  assign done = (state == DONE);

  assign in_ready  = (state == RUN) && (!out_valid || out_ready) && !plane_overrun;
  assign accept    = in_valid && in_ready;

  assign row_end   = (col == LAST_IDX);
  assign plane_end = row_end && (row == LAST_IDX);
  assign frame_end = plane_end && (chan == LAST_CHAN);

  // A window closes on its bottom-right pixel: both coordinates past the
  // first full window and aligned to the stride.
  assign qualify = (row >= WIN_FIRST) && ((row % STRIDE_W) == '0) &&
                   (col >= WIN_FIRST) && ((col % STRIDE_W) == '0);

  assign final_out = out_valid && out_ready && out_last && (out_chan == LAST_CHAN);

  assign v = max3(pix_t'(in_data), lb1_q, lb2_q);

  pool_line_buffer #(
    .IN_DIM (IN_DIM),
    .DATA_W (DATA_W)
  ) u_line_buffer (
    .clk   (clk),
    .we    (accept),
    .idx   (col),
    .wdata (in_data),
    .lb1_q (lb1_q),
    .lb2_q (lb2_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      col           <= '0;
      row           <= '0;
      chan          <= '0;
      plane_overrun <= 1'b0;
      h1            <= '0;
      h2            <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_last      <= 1'b0;
      out_chan      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state         <= RUN;
            col           <= '0;
            row           <= '0;
            chan          <= '0;
            plane_overrun <= 1'b0;
          end
        end
        RUN: begin
          if (final_out) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // Input stage: raster counters and horizontal window shift
      if (accept) begin
        h1 <= v;
        h2 <= h1;
        col <= row_end ? '0 : col + 1'b1;
        if (row_end) row <= (row == LAST_IDX) ? '0 : row + 1'b1;
        if (plane_end) chan <= (chan == LAST_CHAN) ? '0 : chan + 1'b1;
        if (frame_end) plane_overrun <= 1'b1;
      end

      // Output stage: load on a qualifying accept, otherwise drain on ready
      if (accept && qualify) begin
        out_valid <= 1'b1;
        out_data  <= max3(v, h1, h2);
        out_last  <= (row == LAST_POS) && (col == LAST_POS);
        out_chan  <= chan;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_maxpool1_3x3s2.sv
// Bench for maxpool1_3x3s2 with a reduced channel count: directed planes,
// back-pressure, random frames against a window-max reference, and reset abort.
module tb_maxpool1_3x3s2;

  localparam int DW    = 16;
  localparam int IN    = 55;
  localparam int CH    = 2;
  localparam int PO    = 27;
  localparam int NPIX  = IN * IN;
  localparam int NOUT  = PO * PO;
  localparam int LIMIT = 30000;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic                 out_last;
  logic [0:0]           out_chan;
  logic                 busy;
  logic                 done;

  always #5 clk = ~clk;

  maxpool1_3x3s2 #(
    .DATA_W   (DW),
    .IN_DIM   (IN),
    .CHANNELS (CH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_chan  (out_chan),
    .busy      (busy),
    .done      (done)
  );

  int total = 0;
  int bad   = 0;

  int img  [CH][NPIX];
  int expv [CH*NOUT];
  int got  [CH*NOUT];

  typedef struct {
    int frame;
    int ch;
    int pr;
    int pc;
    int want;
  } spot_t;

  spot_t tbl [16];

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: each pooled pixel is the max of its 3x3 input window.
  function automatic void build_expected();
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < PO; i++)
        for (int j = 0; j < PO; j++) begin
          int m;
          m = img[c][(2*i)*IN + 2*j];
          for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
              if (img[c][(2*i+dr)*IN + 2*j+dc] > m) m = img[c][(2*i+dr)*IN + 2*j+dc];
          expv[c*NOUT + i*PO + j] = m;
        end
  endfunction

  task automatic fill_ramp(input int c);
    for (int r = 0; r < IN; r++)
      for (int k = 0; k < IN; k++) img[c][r*IN+k] = r*55 + k;
  endtask

  task automatic fill_random(input int c);
    for (int p = 0; p < NPIX; p++) img[c][p] = int'($urandom_range(65535)) - 32768;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  int'(in_ready),  0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_data"},  int'(out_data),  0);
    check({tag, "_out_last"},  int'(out_last),  0);
    check({tag, "_out_chan"},  int'(out_chan),  0);
    check({tag, "_busy"},      int'(busy),      0);
    check({tag, "_done"},      int'(done),      0);
  endtask

  task automatic spot_checks(input int frame);
    for (int t = 0; t < 16; t++)
      if (tbl[t].frame == frame)
        check($sformatf("spot_f%0d_c%0d_%0d_%0d", frame, tbl[t].ch, tbl[t].pr, tbl[t].pc),
              got[tbl[t].ch*NOUT + tbl[t].pr*PO + tbl[t].pc], tbl[t].want);
  endtask

  // Runs one frame from start; returns at the negedge after the abort point
  // when abort_idx >= 0, otherwise after checking the done pulse.
  task automatic run_frame(input int rdy_pct, input int vld_pct, input int abort_idx);
    int idx, oidx, cyc, held_data;
    bit fin, held;
    idx = 0; oidx = 0; cyc = 0; fin = 0; held = 0; held_data = 0;
    build_expected();
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    while (!fin && cyc < LIMIT) begin
      start     = (cyc == 100);
      out_ready = ($urandom_range(99) < rdy_pct);
      in_valid  = (idx >= CH*NPIX) || ($urandom_range(99) < vld_pct);
      in_data   = (idx < CH*NPIX) ? DW'(img[idx / NPIX][idx % NPIX]) : '0;
      #1;
      check("busy_run", int'(busy), 1);
      if (held) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_data", int'(out_data), held_data);
      end
      held = 0;
      if (out_valid) begin
        if (out_ready) begin
          if (oidx < CH*NOUT) begin
            check($sformatf("data_%0d", oidx), int'(out_data), expv[oidx]);
            check($sformatf("last_%0d", oidx), int'(out_last), int'((oidx % NOUT) == NOUT-1));
            check($sformatf("chan_%0d", oidx), int'(out_chan), oidx / NOUT);
            got[oidx] = int'(out_data);
          end else begin
            check("extra_output", oidx, CH*NOUT - 1);
          end
          oidx++;
          if (oidx == CH*NOUT) fin = 1;
        end else begin
          check("stall_in_ready", int'(in_ready), 0);
          held = 1;
          held_data = int'(out_data);
        end
      end
      if (in_valid && in_ready) begin
        if (idx >= CH*NPIX) check("overrun_accept", int'(in_ready), 0);
        idx++;
      end
      @(negedge clk);
      cyc++;
      if (abort_idx >= 0 && idx >= abort_idx) return;
    end
    start = 1'b0;
    if (!fin) begin
      check("frame_timeout_outputs", oidx, CH*NOUT);
    end else begin
      #1;
      check("done_pulse", int'(done), 1);
      check("busy_in_done", int'(busy), 0);
      @(negedge clk);
      #1;
      check("done_clear", int'(done), 0);
      check("busy_idle", int'(busy), 0);
      check("idle_in_ready", int'(in_ready), 0);
      check("input_count", idx, CH*NPIX);
    end
  endtask

  initial begin
    tbl[0]  = '{0, 0, 0, 0, 112};
    tbl[1]  = '{0, 0, 0, 1, 114};
    tbl[2]  = '{0, 0, 1, 0, 222};
    tbl[3]  = '{0, 0, 26, 26, 3024};
    tbl[4]  = '{0, 1, 1, 1, 500};
    tbl[5]  = '{0, 1, 1, 2, 500};
    tbl[6]  = '{0, 1, 2, 1, 500};
    tbl[7]  = '{0, 1, 2, 2, 500};
    tbl[8]  = '{0, 1, 0, 0, 0};
    tbl[9]  = '{0, 1, 1, 3, 0};
    tbl[10] = '{0, 1, 3, 2, 0};
    tbl[11] = '{1, 0, 0, 0, -1};
    tbl[12] = '{1, 0, 0, 1, -5};
    tbl[13] = '{1, 0, 26, 26, -5};
    tbl[14] = '{1, 1, 0, 0, 112};
    tbl[15] = '{1, 1, 26, 26, 3024};

    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b1;
    in_data = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("idle_offer_in_ready", int'(in_ready), 0);
    check("idle_busy", int'(busy), 0);

    // Frame 0: ramp plane then single hot pixel, no back-pressure
    fill_ramp(0);
    for (int p = 0; p < NPIX; p++) img[1][p] = 0;
    img[1][4*IN+4] = 500;
    run_frame(100, 100, -1);
    spot_checks(0);

    // Frame 1: signed plane then ramp, 30% downstream ready
    for (int p = 0; p < NPIX; p++) img[0][p] = -5;
    img[0][0] = -1;
    fill_ramp(1);
    run_frame(30, 100, -1);
    spot_checks(1);

    // Frame 2: random data with input gaps and a stray start mid-run
    fill_random(0);
    fill_random(1);
    run_frame(70, 80, -1);

    // Frame 3: aborted by reset at row 20 of the first plane
    fill_random(0);
    fill_random(1);
    run_frame(100, 100, 20*IN);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("abort_idle_busy", int'(busy), 0);

    // Frame 4: fresh random frame after the abort
    for (int p = 0; p < NPIX; p++) img[0][p] = -32768 + int'($urandom_range(200));
    fill_random(1);
    run_frame(100, 100, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
